// File: rtl/fwd_operand_stage_if.sv
// ============================================================================
// Module      : fwd_operand_stage_if
// Description : Bundle of the ID/EX operand-stage signals. Carries decoded ID
//               operands, EX/MEM and MEM/WB writeback snoop buses, stall and
//               flush controls, and the forwarded EX-side results.
//               master : pipeline control side (drives ID/snoop/control,
//                        receives operands and EX info)
//               slave  : the operand stage itself
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface fwd_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // ID stage
    logic              Id_valid;
    logic [REG_AW-1:0] Id_rs;
    logic [REG_AW-1:0] Id_rt;
    logic              Id_uses_rs;
    logic              Id_uses_rt;
    logic [DATA_W-1:0] Id_rs_data;
    logic [DATA_W-1:0] Id_rt_data;
    logic [REG_AW-1:0] Id_rd;
    logic              Id_wr;
    logic              Id_is_load;
    // Writeback snoop buses
    logic              Ex_mem_wr;
    logic [REG_AW-1:0] Ex_mem_rd;
    logic [DATA_W-1:0] Ex_mem_data;
    logic              Mem_wb_wr;
    logic [REG_AW-1:0] Mem_wb_rd;
    logic [DATA_W-1:0] Mem_wb_data;
    // Control
    logic              Ext_stall;
    logic              Flush;
    // EX side results
    logic [DATA_W-1:0] Op_a;
    logic [DATA_W-1:0] Op_b;
    logic [1:0]        Fwd_sel_a;
    logic [1:0]        Fwd_sel_b;
    logic              Ex_valid;
    logic [REG_AW-1:0] Ex_rd;
    logic              Ex_wr;
    logic              Ex_is_load;
    logic              Load_use_stall;

    modport master (
        output Id_valid, Id_rs, Id_rt, Id_uses_rs, Id_uses_rt,
               Id_rs_data, Id_rt_data, Id_rd, Id_wr, Id_is_load,
               Ex_mem_wr, Ex_mem_rd, Ex_mem_data,
               Mem_wb_wr, Mem_wb_rd, Mem_wb_data,
               Ext_stall, Flush,
        input  Op_a, Op_b, Fwd_sel_a, Fwd_sel_b,
               Ex_valid, Ex_rd, Ex_wr, Ex_is_load, Load_use_stall
    );

    modport slave (
        input  Id_valid, Id_rs, Id_rt, Id_uses_rs, Id_uses_rt,
               Id_rs_data, Id_rt_data, Id_rd, Id_wr, Id_is_load,
               Ex_mem_wr, Ex_mem_rd, Ex_mem_data,
               Mem_wb_wr, Mem_wb_rd, Mem_wb_data,
               Ext_stall, Flush,
        output Op_a, Op_b, Fwd_sel_a, Fwd_sel_b,
               Ex_valid, Ex_rd, Ex_wr, Ex_is_load, Load_use_stall
    );
endinterface

`default_nettype wire

// File: rtl/fwd_operand_stage.sv
// ============================================================================
// Module      : fwd_operand_stage
// Description : ID/EX operand stage of the MIPS pipeline. Latches decoded
//               operands/dest info, forwards each operand from EX/MEM or
//               MEM/WB (or a held copy during EX-busy stalls), and detects
//               load-use hazards, inserting a single bubble.
// Ports       : Clk  - pipeline clock
//               Rst  - synchronous active-high reset
//               bus  - fwd_operand_stage_if.slave (ID inputs, writeback snoop
//                      buses, Ext_stall/Flush, forwarded operands, EX info,
//                      Load_use_stall)
// Options     : FWD_WB_BYPASS_EN - when defined, the ID latch captures
//               MEM/WB data for sources being written back in the same cycle
//               (for a regfile without write-before-read).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fwd_operand_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_AW        = 5,
    parameter bit ZERO_REG_HARD = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    fwd_operand_stage_if.slave    bus
);

    localparam logic [1:0] c_SEL_RF   = 2'b00;
    localparam logic [1:0] c_SEL_EM   = 2'b01;
    localparam logic [1:0] c_SEL_MW   = 2'b10;
    localparam logic [1:0] c_SEL_HOLD = 2'b11;

    // ID/EX latch
    logic              r_ex_valid;
    logic              r_ex_wr;
    logic              r_ex_is_load;
    logic [REG_AW-1:0] r_ex_rd;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;

    // Operand hold across EX-busy stalls
    logic [DATA_W-1:0] r_hold_a;
    logic [DATA_W-1:0] r_hold_b;
    logic              r_hold_a_vld;
    logic              r_hold_b_vld;

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;
    logic [DATA_W-1:0] w_id_rs_data;
    logic [DATA_W-1:0] w_id_rt_data;
    logic              w_rd_ok;
    logic              w_src_hit;
    logic              w_load_use;

    // Writeback-to-source match; register 0 is excluded when hardwired.
    function automatic logic f_match(input logic              wr,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
        return wr && (rd == src) && ((ZERO_REG_HARD == 1'b0) || (src != '0));
    endfunction

    // Operand select: held > EX/MEM > MEM/WB > latched regfile data
    always_comb begin
        w_op_a  = r_rs_data;
        w_sel_a = c_SEL_RF;
        if (r_hold_a_vld) begin
            w_op_a  = r_hold_a;
            w_sel_a = c_SEL_HOLD;
        end else if (f_match(bus.Ex_mem_wr, bus.Ex_mem_rd, r_rs)) begin
            w_op_a  = bus.Ex_mem_data;
            w_sel_a = c_SEL_EM;
        end else if (f_match(bus.Mem_wb_wr, bus.Mem_wb_rd, r_rs)) begin
            w_op_a  = bus.Mem_wb_data;
            w_sel_a = c_SEL_MW;
        end
    end

    always_comb begin
        w_op_b  = r_rt_data;
        w_sel_b = c_SEL_RF;
        if (r_hold_b_vld) begin
            w_op_b  = r_hold_b;
            w_sel_b = c_SEL_HOLD;
        end else if (f_match(bus.Ex_mem_wr, bus.Ex_mem_rd, r_rt)) begin
            w_op_b  = bus.Ex_mem_data;
            w_sel_b = c_SEL_EM;
        end else if (f_match(bus.Mem_wb_wr, bus.Mem_wb_rd, r_rt)) begin
            w_op_b  = bus.Mem_wb_data;
            w_sel_b = c_SEL_MW;
        end
    end

    // Load-use hazard. Once the bubble is latched Ex_valid drops, so the
    // stall can only last one cycle per hazard.
    assign w_rd_ok    = (ZERO_REG_HARD == 1'b0) || (r_ex_rd != '0);
    assign w_src_hit  = (bus.Id_uses_rs && (bus.Id_rs == r_ex_rd)) ||
                        (bus.Id_uses_rt && (bus.Id_rt == r_ex_rd));
    assign w_load_use = bus.Id_valid && r_ex_valid && r_ex_is_load && r_ex_wr &&
                        w_rd_ok && w_src_hit && !bus.Ext_stall && !bus.Flush;

`ifdef FWD_WB_BYPASS_EN
    // Regfile read does not see a same-cycle write; patch it here.
    assign w_id_rs_data = f_match(bus.Mem_wb_wr, bus.Mem_wb_rd, bus.Id_rs) ?
                          bus.Mem_wb_data : bus.Id_rs_data;
    assign w_id_rt_data = f_match(bus.Mem_wb_wr, bus.Mem_wb_rd, bus.Id_rt) ?
                          bus.Mem_wb_data : bus.Id_rt_data;
`else
    assign w_id_rs_data = bus.Id_rs_data;
    assign w_id_rt_data = bus.Id_rt_data;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_wr      <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_ex_rd      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_hold_a     <= '0;
            r_hold_b     <= '0;
            r_hold_a_vld <= 1'b0;
            r_hold_b_vld <= 1'b0;
        end else if (bus.Flush) begin
            r_ex_valid   <= 1'b0;
            r_ex_wr      <= 1'b0;
            r_hold_a_vld <= 1'b0;
            r_hold_b_vld <= 1'b0;
        end else if (bus.Ext_stall) begin
            // Snapshot operands on stall entry only; later stages keep
            // draining so the live forwarding sources go stale.
            if (!r_hold_a_vld) begin
                r_hold_a     <= w_op_a;
                r_hold_a_vld <= 1'b1;
            end
            if (!r_hold_b_vld) begin
                r_hold_b     <= w_op_b;
                r_hold_b_vld <= 1'b1;
            end
        end else if (w_load_use) begin
            r_ex_valid   <= 1'b0;
            r_ex_wr      <= 1'b0;
            r_hold_a_vld <= 1'b0;
            r_hold_b_vld <= 1'b0;
        end else begin
            r_ex_valid   <= bus.Id_valid;
            r_ex_wr      <= bus.Id_wr;
            r_ex_is_load <= bus.Id_is_load;
            r_ex_rd      <= bus.Id_rd;
            r_rs         <= bus.Id_rs;
            r_rt         <= bus.Id_rt;
            r_rs_data    <= w_id_rs_data;
            r_rt_data    <= w_id_rt_data;
            r_hold_a_vld <= 1'b0;
            r_hold_b_vld <= 1'b0;
        end
    end

    assign bus.Op_a           = w_op_a;
    assign bus.Op_b           = w_op_b;
    assign bus.Fwd_sel_a      = w_sel_a;
    assign bus.Fwd_sel_b      = w_sel_b;
    assign bus.Ex_valid       = r_ex_valid;
    assign bus.Ex_rd          = r_ex_rd;
    assign bus.Ex_wr          = r_ex_wr;
    assign bus.Ex_is_load     = r_ex_is_load;
    assign bus.Load_use_stall = w_load_use;

endmodule

`default_nettype wire

// File: tb/tb_fwd_operand_stage.sv
// ============================================================================
// Module      : tb_fwd_operand_stage
// Description : Self-checking bench for fwd_operand_stage. Instance u_dut0
//               uses ZERO_REG_HARD=1, u_dut1 uses ZERO_REG_HARD=0 and shares
//               the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fwd_operand_stage;

    logic Clk;
    logic Rst;

    fwd_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus0 ();
    fwd_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus1 ();

    fwd_operand_stage #(.DATA_W(32), .REG_AW(5), .ZERO_REG_HARD(1'b1)) u_dut0 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus0.slave)
    );

    fwd_operand_stage #(.DATA_W(32), .REG_AW(5), .ZERO_REG_HARD(1'b0)) u_dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1.slave)
    );

    assign bus1.Id_valid    = bus0.Id_valid;
    assign bus1.Id_rs       = bus0.Id_rs;
    assign bus1.Id_rt       = bus0.Id_rt;
    assign bus1.Id_uses_rs  = bus0.Id_uses_rs;
    assign bus1.Id_uses_rt  = bus0.Id_uses_rt;
    assign bus1.Id_rs_data  = bus0.Id_rs_data;
    assign bus1.Id_rt_data  = bus0.Id_rt_data;
    assign bus1.Id_rd       = bus0.Id_rd;
    assign bus1.Id_wr       = bus0.Id_wr;
    assign bus1.Id_is_load  = bus0.Id_is_load;
    assign bus1.Ex_mem_wr   = bus0.Ex_mem_wr;
    assign bus1.Ex_mem_rd   = bus0.Ex_mem_rd;
    assign bus1.Ex_mem_data = bus0.Ex_mem_data;
    assign bus1.Mem_wb_wr   = bus0.Mem_wb_wr;
    assign bus1.Mem_wb_rd   = bus0.Mem_wb_rd;
    assign bus1.Mem_wb_data = bus0.Mem_wb_data;
    assign bus1.Ext_stall   = bus0.Ext_stall;
    assign bus1.Flush       = bus0.Flush;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic        em_wr;
        logic [4:0]  em_rd;
        logic [31:0] em_d;
        logic        mw_wr;
        logic [4:0]  mw_rd;
        logic [31:0] mw_d;
        logic [31:0] exp_a;
        logic [1:0]  exp_sa;
        logic [31:0] exp_b;
        logic [1:0]  exp_sb;
    } vec_t;

    vec_t vecs [6];
    int   n_total;
    int   n_bad;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [31:0] rs_d,
                          input logic [4:0] rt, input logic [31:0] rt_d,
                          input logic [4:0] rd, input logic wr, input logic ld);
        bus0.Id_valid   = 1'b1;
        bus0.Id_rs      = rs;
        bus0.Id_rs_data = rs_d;
        bus0.Id_uses_rs = 1'b1;
        bus0.Id_rt      = rt;
        bus0.Id_rt_data = rt_d;
        bus0.Id_uses_rt = 1'b1;
        bus0.Id_rd      = rd;
        bus0.Id_wr      = wr;
        bus0.Id_is_load = ld;
    endtask

    task automatic set_em(input logic wr, input logic [4:0] rd, input logic [31:0] d);
        bus0.Ex_mem_wr   = wr;
        bus0.Ex_mem_rd   = rd;
        bus0.Ex_mem_data = d;
    endtask

    task automatic set_mw(input logic wr, input logic [4:0] rd, input logic [31:0] d);
        bus0.Mem_wb_wr   = wr;
        bus0.Mem_wb_rd   = rd;
        bus0.Mem_wb_data = d;
    endtask

    initial begin
        logic [31:0] exp_byp;
        n_total = 0;
        n_bad   = 0;

        //           rs  rt  rs_d          rt_d          em_wr em_rd em_d          mw_wr mw_rd mw_d          exp_a         sa     exp_b         sb
        vecs[0] = '{5'd5, 5'd6, 32'h11,     32'h22,     1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd5, 32'hBBBB0002, 32'hAAAA0001, 2'b01, 32'h22,       2'b00};
        vecs[1] = '{5'd5, 5'd6, 32'h11,     32'h22,     1'b0, 5'd5, 32'hAAAA0001, 1'b1, 5'd5, 32'hBBBB0002, 32'hBBBB0002, 2'b10, 32'h22,       2'b00};
        vecs[2] = '{5'd0, 5'd7, 32'h33,     32'h44,     1'b1, 5'd0, 32'hDEAD,     1'b1, 5'd7, 32'h77,       32'h33,       2'b00, 32'h77,       2'b10};
        vecs[3] = '{5'd9, 5'd9, 32'h1,      32'h2,      1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 32'h55,       32'h99,       2'b01, 32'h99,       2'b01};
        vecs[4] = '{5'd3, 5'd4, 32'h3030,   32'h4040,   1'b0, 5'd3, 32'h1,        1'b0, 5'd4, 32'h2,        32'h3030,     2'b00, 32'h4040,     2'b00};
        vecs[5] = '{5'd3, 5'd4, 32'h3030,   32'h4040,   1'b1, 5'd4, 32'h4444,     1'b1, 5'd3, 32'h3333,     32'h3333,     2'b10, 32'h4444,     2'b01};

        // ---------------- Reset with random inputs ----------------
        Rst = 1'b1;
        bus0.Ext_stall = 1'b0;
        bus0.Flush     = 1'b0;
        set_id(5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom), 1'b1, 1'b1);
        set_em(1'b1, 5'($urandom), $urandom);
        set_mw(1'b1, 5'($urandom), $urandom);
        step();
        step();
        check("rst_ex_valid", 32'(bus0.Ex_valid), 32'd0);
        check("rst_ex_wr",    32'(bus0.Ex_wr), 32'd0);
        check("rst_ex_load",  32'(bus0.Ex_is_load), 32'd0);
        check("rst_ex_rd",    32'(bus0.Ex_rd), 32'd0);
        check("rst_op_a",     bus0.Op_a, 32'd0);
        check("rst_op_b",     bus0.Op_b, 32'd0);
        check("rst_sel_a",    32'(bus0.Fwd_sel_a), 32'd0);
        check("rst_sel_b",    32'(bus0.Fwd_sel_b), 32'd0);
        check("rst_lus",      32'(bus0.Load_use_stall), 32'd0);
        Rst = 1'b0;

        // ---------------- Forwarding table ----------------
        for (int i = 0; i < 6; i++) begin
            set_id(vecs[i].rs, vecs[i].rs_d, vecs[i].rt, vecs[i].rt_d, 5'd30, 1'b0, 1'b0);
            set_em(1'b0, 5'd0, 32'd0);
            set_mw(1'b0, 5'd0, 32'd0);
            step();
            set_em(vecs[i].em_wr, vecs[i].em_rd, vecs[i].em_d);
            set_mw(vecs[i].mw_wr, vecs[i].mw_rd, vecs[i].mw_d);
            #1;
            check($sformatf("vec%0d_op_a", i), bus0.Op_a, vecs[i].exp_a);
            check($sformatf("vec%0d_sel_a", i), 32'(bus0.Fwd_sel_a), 32'(vecs[i].exp_sa));
            check($sformatf("vec%0d_op_b", i), bus0.Op_b, vecs[i].exp_b);
            check($sformatf("vec%0d_sel_b", i), 32'(bus0.Fwd_sel_b), 32'(vecs[i].exp_sb));
        end

        // ---------------- Zero register, hard vs soft ----------------
        set_id(5'd0, 32'h33, 5'd1, 32'h10, 5'd30, 1'b0, 1'b0);
        set_em(1'b0, 5'd0, 32'd0);
        set_mw(1'b0, 5'd0, 32'd0);
        step();
        set_em(1'b1, 5'd0, 32'hDEAD);
        #1;
        check("zero_hard_op_a",  bus0.Op_a, 32'h33);
        check("zero_hard_sel_a", 32'(bus0.Fwd_sel_a), 32'd0);
        check("zero_soft_op_a",  bus1.Op_a, 32'hDEAD);
        check("zero_soft_sel_a", 32'(bus1.Fwd_sel_a), 32'd1);

        // ---------------- Load-use hazard ----------------
        set_em(1'b0, 5'd0, 32'd0);
        set_id(5'd1, 32'h1, 5'd0, 32'h0, 5'd8, 1'b1, 1'b1);   // lw r8
        bus0.Id_uses_rt = 1'b0;
        #1;
        check("lu_pre_lus", 32'(bus0.Load_use_stall), 32'd0);
        step();
        set_id(5'd2, 32'h2, 5'd8, 32'hBAD, 5'd10, 1'b1, 1'b0); // add r10, r2, r8
        #1;
        check("lu_stall", 32'(bus0.Load_use_stall), 32'd1);
        step();
        check("lu_bubble_valid", 32'(bus0.Ex_valid), 32'd0);
        check("lu_bubble_wr",    32'(bus0.Ex_wr), 32'd0);
        check("lu_stall_once",   32'(bus0.Load_use_stall), 32'd0);
        set_em(1'b1, 5'd8, 32'h0);   // load now in MEM
        step();
        check("lu_issue_valid", 32'(bus0.Ex_valid), 32'd1);
        check("lu_issue_rd",    32'(bus0.Ex_rd), 32'd10);
        set_em(1'b0, 5'd0, 32'd0);   // bubble in MEM
        set_mw(1'b1, 5'd8, 32'h1234ABCD);
        #1;
        check("lu_fwd_op_b",  bus0.Op_b, 32'h1234ABCD);
        check("lu_fwd_sel_b", 32'(bus0.Fwd_sel_b), 32'd2);
        check("lu_post_lus",  32'(bus0.Load_use_stall), 32'd0);

        // ---------------- EX-busy hold ----------------
        set_mw(1'b0, 5'd0, 32'd0);
        set_id(5'd13, 32'h13, 5'd12, 32'h1, 5'd11, 1'b1, 1'b0);
        step();
        set_em(1'b1, 5'd12, 32'h12345678);
        #1;
        check("hold_pre_op_b",  bus0.Op_b, 32'h12345678);
        check("hold_pre_sel_b", 32'(bus0.Fwd_sel_b), 32'd1);
        bus0.Ext_stall = 1'b1;
        set_id(5'd14, 32'h140, 5'd15, 32'h150, 5'd20, 1'b1, 1'b0);
        step();
        set_em(1'b1, 5'd12, 32'hFFFF0000);
        set_mw(1'b1, 5'd12, 32'h0F0F0F0F);
        #1;
        check("hold1_op_b",  bus0.Op_b, 32'h12345678);
        check("hold1_sel_b", 32'(bus0.Fwd_sel_b), 32'd3);
        check("hold1_op_a",  bus0.Op_a, 32'h13);
        check("hold1_sel_a", 32'(bus0.Fwd_sel_a), 32'd3);
        step();
        set_em(1'b1, 5'd12, 32'hCCCC0000);
        step();
        check("hold3_op_b", bus0.Op_b, 32'h12345678);
        check("hold3_ex_rd", 32'(bus0.Ex_rd), 32'd11);
        bus0.Ext_stall = 1'b0;
        set_em(1'b0, 5'd0, 32'd0);
        set_mw(1'b0, 5'd0, 32'd0);
        step();
        check("rel_op_a",  bus0.Op_a, 32'h140);
        check("rel_sel_a", 32'(bus0.Fwd_sel_a), 32'd0);
        check("rel_ex_rd", 32'(bus0.Ex_rd), 32'd20);
        check("rel_valid", 32'(bus0.Ex_valid), 32'd1);

        // ---------------- Flush during Ext_stall ----------------
        bus0.Ext_stall = 1'b1;
        step();
        check("fl_hold_sel_a", 32'(bus0.Fwd_sel_a), 32'd3);
        bus0.Flush = 1'b1;
        #1;
        check("fl_lus_forced", 32'(bus0.Load_use_stall), 32'd0);
        step();
        check("fl_valid", 32'(bus0.Ex_valid), 32'd0);
        check("fl_wr",    32'(bus0.Ex_wr), 32'd0);
        check("fl_sel_a", 32'(bus0.Fwd_sel_a), 32'd0);
        bus0.Flush     = 1'b0;
        bus0.Ext_stall = 1'b0;

        // ---------------- Writeback bypass into latch ----------------
        set_id(5'd3, 32'h1111, 5'd4, 32'h4, 5'd21, 1'b1, 1'b0);
        set_mw(1'b1, 5'd3, 32'h0000CAFE);
        step();
        set_mw(1'b0, 5'd0, 32'd0);
        #1;
`ifdef FWD_WB_BYPASS_EN
        exp_byp = 32'h0000CAFE;
`else
        exp_byp = 32'h1111;
`endif
        check("byp_op_a",  bus0.Op_a, exp_byp);
        check("byp_sel_a", 32'(bus0.Fwd_sel_a), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
- Parametrised ID/EX operand stage for the MIPS pipeline; successor to the fixed 3-input forward mux.
- Registers decoded operands and dest info from ID, and selects per-operand forwarding (regfile / EX-MEM / MEM-WB / held) internally.
- Detects load-use hazards and inserts exactly one bubble.
- Holds forwarded operands across EX-busy stalls while later stages drain.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- ZERO_REG_HARD, 1, 1 = register 0 never matches a forward source.

Ports:
- Clk  in  1  pipeline clock
- Rst  in  1  reset, synchronous, active-high
- Id_valid  in  1  valid instruction in ID
- Id_rs, Id_rt  in  REG_AW  ID source regs
- Id_uses_rs, Id_uses_rt  in  1  source actually read
- Id_rs_data, Id_rt_data  in  DATA_W  regfile read data
- Id_rd  in  REG_AW  ID dest reg
- Id_wr  in  1  ID writes a register
- Id_is_load  in  1  ID instruction is a load
- Ex_mem_wr  in  1  EX/MEM writeback enable
- Ex_mem_rd  in  REG_AW  EX/MEM dest
- Ex_mem_data  in  DATA_W  EX/MEM result
- Mem_wb_wr  in  1  MEM/WB writeback enable
- Mem_wb_rd  in  REG_AW  MEM/WB dest
- Mem_wb_data  in  DATA_W  MEM/WB result
- Ext_stall  in  1  EX busy; hold this stage
- Flush  in  1  kill ID/EX contents (branch mispredict)
- Op_a, Op_b  out  DATA_W  forwarded EX operands
- Fwd_sel_a, Fwd_sel_b  out  2  00 regfile, 01 EX/MEM, 10 MEM/WB, 11 held
- Ex_valid  out  1  EX instruction valid
- Ex_rd  out  REG_AW  latched dest
- Ex_wr  out  1  latched write enable
- Ex_is_load  out  1  latched load flag
- Load_use_stall  out  1  freeze PC/IF/ID this cycle

Behaviour:
- Reset (Rst at Clk edge):
  - All latches, hold registers and hold flags cleared.
  - Ex_valid=0, Ex_wr=0, Ex_is_load=0, Ex_rd=0.
  - Op_a=Op_b=0, Fwd_sel_a=Fwd_sel_b=00, Load_use_stall=0.
- Edge update priority: Rst > Flush > Ext_stall > Load_use_stall > advance.
  - Flush: Ex_valid<=0, Ex_wr<=0, hold flags cleared; other latch fields don't-care.
  - Ext_stall: ID/EX latch unchanged. On the first stalled edge (hold flag clear), capture current Op_a/Op_b into hold regs and set both hold flags. Later stalled edges leave the hold regs untouched.
  - Load_use_stall (no Ext_stall): bubble; Ex_valid<=0, Ex_wr<=0, hold flags cleared.
  - Advance: latch all ID fields, Ex_valid<=Id_valid, hold flags cleared.
- Latency: ID to EX is 1 cycle. Operand mux and Load_use_stall are combinational from latched state and current inputs.
- Load_use_stall = Id_valid & Ex_valid & Ex_is_load & Ex_wr & (Ex_rd!=0 when ZERO_REG_HARD) & ((Id_uses_rs & Id_rs==Ex_rd) | (Id_uses_rt & Id_rt==Ex_rd)).
  - Forced 0 while Ext_stall or Flush.
  - Asserts for exactly one cycle per hazard.
- Operand select, per operand, first match wins:
  - hold flag set -> held value, sel 11
  - Ex_mem_wr & Ex_mem_rd==src & src nonzero -> Ex_mem_data, 01
  - Mem_wb_wr & Mem_wb_rd==src & src nonzero -> Mem_wb_data, 10
  - otherwise latched regfile data, 00
- "src nonzero" is ignored when ZERO_REG_HARD=0.
- Operands whose uses bit is 0 still select normally; the result is don't-care for EX.
- Reset asserted mid-stall discards held data. Flush during Ext_stall wins over the stall.

Optional Feature:
- Macro FWD_WB_BYPASS_EN.
- Defined: on an advance edge, for each source with Mem_wb_wr & Mem_wb_rd==Id_src (nonzero rule applies), the latch takes Mem_wb_data instead of Id_*_data. This covers a regfile without write-before-read.
- Undefined: the latch always takes Id_*_data, and the regfile must provide internal write-first bypass.

Test Plan:
- Reset: Rst high 2 cycles with random inputs -> Ex_valid=0, Op_a=Op_b=0, sels 00, Load_use_stall=0.
- Forward priority: latched rs=5; Ex_mem_wr=1/rd=5/data=0xAAAA0001; Mem_wb_wr=1/rd=5/data=0xBBBB0002 -> Op_a=0xAAAA0001, sel 01. Drop Ex_mem_wr -> 0xBBBB0002, sel 10.
- Zero register: rs=0, Ex_mem_rd=0, Ex_mem_wr=1 -> Op_a=regfile data, sel 00. Same with ZERO_REG_HARD=0 -> sel 01.
- Load-use: EX holds lw to r8; ID uses rt=8 -> Load_use_stall=1 for exactly one cycle; next edge Ex_valid=0; following edge latches the ID instruction; MEM/WB forwarding supplies the load data.
- EX-busy hold: Op_b from EX/MEM=0x12345678 at stall entry; Ext_stall 3 cycles while Ex_mem/Mem_wb change to other values -> Op_b stays 0x12345678, sel 11; on release, hold flags clear and new ID is latched.
- Flush/bypass: Flush with Ext_stall -> Ex_valid=0 next cycle. With FWD_WB_BYPASS_EN, advance with Mem_wb_rd=Id_rs=3, data=0x0000CAFE, stale regfile data -> Op_a=0x0000CAFE, sel 00.
